// File: rtl/fm_phase_gen.sv
// fm_phase_gen: per-operator 19-bit phase accumulator sweeping 64 slots per sample tick
module fm_phase_gen #(
    parameter int SLOT_BITS  = 6,
    parameter int PHASE_BITS = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    output logic [SLOT_BITS-2:0] ch_sel,
    input  logic [2:0]           ch_block,
    input  logic [9:0]           ch_fnum,
    output logic [SLOT_BITS-1:0] op_sel,
    input  logic [3:0]           op_mult,
    input  logic                 op_phase_rst,
    output logic                 out_valid,
    output logic [SLOT_BITS-1:0] out_slot,
    output logic [9:0]           out_phase,
    output logic                 busy,
    output logic                 overrun
);
    localparam logic [SLOT_BITS-1:0] LAST = '1;
    localparam logic [4:0] M2 [16] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14,
                                       5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30};

    typedef enum logic [1:0] {CLEAR, IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [SLOT_BITS-1:0]    clr_q, clr_d, sel_q, sel_d;
    logic                    b_valid_q, b_valid_d, b_rst_q, b_rst_d;
    logic [SLOT_BITS-1:0]    b_slot_q, b_slot_d;
    logic [2:0]              b_block_q, b_block_d;
    logic [9:0]              b_fnum_q, b_fnum_d;
    logic [3:0]              b_mult_q, b_mult_d;
    logic                    out_valid_q, out_valid_d, busy_q, busy_d, overrun_q, overrun_d;
    logic [SLOT_BITS-1:0]    out_slot_q, out_slot_d;
    logic [9:0]              out_phase_q, out_phase_d;
    logic [PHASE_BITS-1:0]   phase_ram [2**SLOT_BITS];
    logic [21:0]             prod;
    logic [PHASE_BITS-1:0]   inc, new_phase, ram_wdata;
    logic [SLOT_BITS-1:0]    ram_addr;
    logic                    ram_we;

    assign ch_sel    = sel_q[SLOT_BITS-1:1];
    assign op_sel    = sel_q;
    assign out_valid = out_valid_q;
    assign out_slot  = out_slot_q;
    assign out_phase = out_phase_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

    // Sweep control: CLEAR zeroes the RAM once, RUN walks slots 0..63 after a tick
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        sel_d   = sel_q;
        case (state_q)
            CLEAR: begin
                clr_d   = clr_q + 1'b1;
                state_d = (clr_q == LAST) ? IDLE : CLEAR;
            end
            IDLE: begin
                state_d = sample_tick ? RUN : IDLE;
                sel_d   = sample_tick ? '0 : sel_q;
            end
            RUN: begin
                state_d = (sel_q == LAST) ? IDLE : RUN;
                sel_d   = (sel_q == LAST) ? sel_q : sel_q + 1'b1;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Stage B accumulate plus RAM write port shared between CLEAR and RUN
    always_comb begin
        b_valid_d   = (state_q == RUN);
        b_slot_d    = sel_q;
        b_block_d   = ch_block;
        b_fnum_d    = ch_fnum;
        b_mult_d    = op_mult;
        b_rst_d     = op_phase_rst;
        prod        = ({12'd0, b_fnum_q} << b_block_q) * {17'd0, M2[b_mult_q]};
        inc         = PHASE_BITS'(prod >> 2);
        new_phase   = b_rst_q ? '0 : phase_ram[b_slot_q] + inc;
        ram_we      = (state_q == CLEAR) || b_valid_q;
        ram_addr    = (state_q == CLEAR) ? clr_q : b_slot_q;
        ram_wdata   = (state_q == CLEAR) ? '0 : new_phase;
        out_valid_d = b_valid_q;
        out_slot_d  = b_valid_q ? b_slot_q : out_slot_q;
        out_phase_d = b_valid_q ? new_phase[PHASE_BITS-1 -: 10] : out_phase_q;
        busy_d      = (state_d == RUN) || (state_q == CLEAR) || b_valid_d;
        overrun_d   = sample_tick && (state_q != IDLE);
    end

    // Phase storage is deliberately unreset; the CLEAR sweep initialises it
    always_ff @(posedge clk) begin
        if (ram_we) phase_ram[ram_addr] <= ram_wdata;
    end

    // Control, pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_q       <= '0;
            sel_q       <= '0;
            b_valid_q   <= 1'b0;
            b_slot_q    <= '0;
            b_block_q   <= '0;
            b_fnum_q    <= '0;
            b_mult_q    <= '0;
            b_rst_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_slot_q  <= '0;
            out_phase_q <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            sel_q       <= sel_d;
            b_valid_q   <= b_valid_d;
            b_slot_q    <= b_slot_d;
            b_block_q   <= b_block_d;
            b_fnum_q    <= b_fnum_d;
            b_mult_q    <= b_mult_d;
            b_rst_q     <= b_rst_d;
            out_valid_q <= out_valid_d;
            out_slot_q  <= out_slot_d;
            out_phase_q <= out_phase_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end
endmodule
